// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO with flush; head is valid whenever empty=0.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    // A pop in the same cycle frees the slot, so push at full is still legal.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues imem requests under a credit limit, buffers
// in-order responses for decode and drops wrong-path responses after redirects.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          run_reg;
    logic [31:0]   pc_reg;
    logic [CW-1:0] discard_reg;
    logic [CW-1:0] discard_next;

    logic [31:0]   addr_head;
    logic [CW-1:0] tracked;
    logic          addr_full;
    logic          addr_empty;
    fetch_entry_t  buf_head;
    fetch_entry_t  buf_in;
    logic [CW-1:0] buf_count;
    logic          buf_full;
    logic          buf_empty;

    logic [CW:0]   used_credit;
    logic          req_fire;
    logic          rsp_any;
    logic          rsp_live;
    logic          rsp_drop;
    logic          dec_fire;
    logic          addr_push;
    logic          addr_pop;
    logic          buf_push;

    // Every slot in flight (live or doomed) or buffered consumes one credit.
    assign used_credit    = {1'b0, tracked} + {1'b0, discard_reg} + {1'b0, buf_count};
    assign imem_req_valid = run_reg && (used_credit < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc_reg;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_any  = imem_rsp_valid && (!addr_empty || (discard_reg != '0));
    assign rsp_live = rsp_any && (discard_reg == '0);
    assign rsp_drop = rsp_any && (discard_reg != '0);
    assign dec_fire = if_valid && if_ready;

    assign addr_push = req_fire && !redirect_valid && !addr_full;
    assign addr_pop  = rsp_live && !redirect_valid;
    assign buf_push  = rsp_live && !redirect_valid && !(buf_full && !dec_fire);
    assign buf_in    = '{pc: addr_head, instr: imem_rsp_data};

    assign if_valid = !buf_empty;
    assign if_instr = if_valid ? buf_head.instr : NOP_INSTR;
    assign if_pc    = if_valid ? buf_head.pc : pc_reg;

    // On redirect every request still owed by imem becomes a discard.
    always_comb begin
        discard_next = discard_reg;
        if (redirect_valid)
            discard_next = tracked + discard_reg - CW'(rsp_any) + CW'(req_fire);
        else if (rsp_drop)
            discard_next = discard_reg - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_reg     <= 1'b0;
            pc_reg      <= RESET_PC;
            discard_reg <= '0;
        end else begin
            run_reg     <= 1'b1;
            discard_reg <= discard_next;
            if (redirect_valid)
                pc_reg <= redirect_pc & 32'hFFFF_FFFC;
            else if (req_fire)
                pc_reg <= pc_reg + 32'd4;
        end
    end

    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_addr_q (
        .clk       (clk),
        .rst       (rst),
        .push      (addr_push),
        .push_data (pc_reg),
        .pop       (addr_pop),
        .flush     (redirect_valid),
        .head      (addr_head),
        .count     (tracked),
        .full      (addr_full),
        .empty     (addr_empty)
    );

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data (buf_in),
        .pop       (dec_fire),
        .flush     (redirect_valid),
        .head      (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and random stimulus for fetch_unit against a stream-level model:
// decode must see consecutive PCs from the last redirect with matching words.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        imem_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          epoch = 0;
    int          buf_n = 0;
    bit          started = 0;
    logic [31:0] exp_req   = RESET_PC;
    logic [31:0] expect_pc = RESET_PC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: check post-edge state, drive inputs, advance the model.
    task automatic step(input bit rdy, input int lat, input bit drdy,
                        input bit redir, input logic [31:0] tgt);
        bit   exp_valid;
        bit   fire;
        bit   rsp;
        bit   dec;
        req_t r;
        exp_valid = started && ((imem_q.size() + buf_n) < DEPTH);

        chk("if_valid", {31'b0, if_valid}, {31'b0, buf_n > 0});
        if (buf_n > 0) begin
            chk("if_pc", if_pc, expect_pc);
            chk("if_instr", if_instr, mem_word(expect_pc));
        end else begin
            chk("nop_when_idle", if_instr, NOP_INSTR);
        end
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_valid});
        if (exp_valid) chk("req_addr", imem_req_addr, exp_req);

        imem_req_ready = rdy;
        if (imem_q.size() > 0 && imem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(imem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        if_ready       = drdy;
        redirect_valid = redir;
        redirect_pc    = tgt;

        fire = exp_valid && rdy;
        rsp  = imem_rsp_valid;
        dec  = (buf_n > 0) && drdy;
        if (dec) begin
            buf_n--;
            expect_pc += 32'd4;
        end
        if (rsp) begin
            r = imem_q.pop_front();
            if (r.epoch == epoch && !redir) buf_n++;
        end
        if (fire) begin
            imem_q.push_back('{exp_req, epoch, cyc + lat});
            exp_req += 32'd4;
        end
        if (redir) begin
            epoch++;
            buf_n     = 0;
            exp_req   = tgt & 32'hFFFF_FFFC;
            expect_pc = tgt & 32'hFFFF_FFFC;
        end

        @(posedge clk);
        cyc++;
        started = 1;
        @(negedge clk);
    endtask

    // Asynchronous assertion away from any edge, outputs checked before the next edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instr, NOP_INSTR);
        chk("rst_if_pc", if_pc, RESET_PC);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        imem_q.delete();
        buf_n     = 0;
        epoch++;
        started   = 0;
        exp_req   = RESET_PC;
        expect_pc = RESET_PC;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Streaming with 1-cycle latency.
        for (int i = 0; i < 30; i++) step(1, 1, 1, 0, '0);

        // imem not ready: address and valid must hold.
        do_reset();
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, '0);
        for (int i = 0; i < 8; i++) step(1, 1, 1, 0, '0);

        // Decode stalled: credits run out at DEPTH, then issue resumes.
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, '0);
        for (int i = 0; i < 12; i++) step(1, 1, 1, 0, '0);

        // Latency 3 with requests outstanding, then redirect to an unaligned target.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 3, 1, 0, '0);
        step(1, 3, 1, 1, 32'h0000_0103);
        for (int i = 0; i < 14; i++) step(1, 3, 1, 0, '0);

        // Redirect coinciding with response and fire, then back-to-back redirect.
        for (int i = 0; i < 8; i++) step(1, 2, 1, 0, '0);
        step(1, 2, 1, 1, 32'h0000_0300);
        step(1, 2, 1, 1, 32'h0000_0200);
        for (int i = 0; i < 12; i++) step(1, 2, 1, 0, '0);

        // Redirect while decode is stalled, and PC wrap at the top of memory.
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, '0);
        step(1, 1, 0, 1, 32'hFFFF_FFF9);
        for (int i = 0; i < 14; i++) step(1, 1, 1, 0, '0);

        // Random mix of backpressure, latency and redirects.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(1, 4), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0, $urandom);

        // Reset in the middle of a stalled, full pipeline.
        for (int i = 0; i < 8; i++) step(1, 2, 0, 0, '0);
        do_reset();
        for (int i = 0; i < 12; i++) step(1, 1, 1, 0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
